mod_n_counter: RTL
==================

Name: mod_n_counter

Overview:
Parametrised modulo-N digit counter for the timer input path. It generalises the fixed 0..7 counter to any modulus and width. It adds up/down counting, synchronous load, a wrap or saturate mode, and a carry-in/carry-out chain, so that MM:SS timer digits (mod 10, mod 6) can be cascaded. The block sits between the keypad/timer-entry logic and the display/countdown controller.

Parameters:
WIDTH, 4, bit width of value and load_val; must satisfy 2^WIDTH >= MODULO
MODULO, 10, count range 0..MODULO-1; legal range 2..2^WIDTH
RESET_VAL, 0, value taken on reset; must be < MODULO
WRAP, 1, 1 = wrap at terminal count; 0 = saturate (hold) at terminal count

Ports:
clk  input  1  system clock, rising edge active
clr  input  1  asynchronous active-low reset
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
cin  input  1  cascade carry/borrow in; tie to 1 on the least-significant digit
value  output  WIDTH  registered count
cout  output  1  cascade carry/borrow out, combinational
zero  output  1  value == 0, combinational from the register

Behaviour:
- Reset: clr=0 asynchronously forces value=RESET_VAL. zero reflects RESET_VAL. cout=0.
- Reset release: the first count edge is the first rising clk with clr=1. Deassertion is treated as synchronous to clk upstream.
- step = en & cin & ~load. terminal = (up ? value==MODULO-1 : value==0).
- Priority at each rising clk, clr=1:
  1. load=1: value <= (load_val >= MODULO) ? MODULO-1 : load_val. Load is independent of en and cin.
  2. step=1 and not terminal: value <= value+1 (up) or value-1 (down). Latency is 1 cycle.
  3. step=1 and terminal, WRAP=1: value <= 0 (up) or MODULO-1 (down).
  4. step=1 and terminal, WRAP=0: value holds.
  5. Otherwise value holds.
- cout = step & terminal, in both modes. Successor digits therefore advance or borrow on the same edge, with no extra latency per stage.
- A direction change takes effect on the next edge. There is no pipeline state other than value.
- Intermediate arithmetic is WIDTH+1 bits, so no overflow occurs when MODULO = 2^WIDTH.
- value never leaves 0..MODULO-1 after reset.
- clr asserted mid-count overrides everything immediately, including a load in the same cycle.
- en=0 or cin=0 freezes value and forces cout=0. Load still works in that state.
- zero is a pure decode of value. It is valid in the same cycle that value changes.

Test Plan:
- Reset/count, MODULO=8, WIDTH=3, up=1, en=cin=1: clr=0 for 2 cycles gives value=0. Releasing clr gives 20 edges with values 1..7,0,1..7,0,1..4. cout is high while value=7 (cycles 7 and 15). Re-asserting clr gives value=0 asynchronously, mid-cycle.
- Down wrap, MODULO=10: load 2, then down for 4 edges gives 1,0,9,8. cout is high only while value=0. zero is high only while value=0.
- Saturate, WRAP=0, MODULO=6: load 4, then up for 4 edges gives 5,5,5,5. cout stays high while value=5 and step=1. Switching to down gives 4.
- Load clamp/priority, MODULO=6, WIDTH=4: load_val=9 with load=1 and en=1 gives value=5 (no step that cycle). load with en=0 still loads. load and clr=0 together give RESET_VAL.
- Cascade, seconds-units mod10 (cin=1) chained to seconds-tens mod6 (cin = units cout), countdown from 10 (tens=1, units=0): edges give 09, 08 ... 00. At 00 both cout signals are high. With WRAP=1 the next edge gives 59.
- Gating: holding en=0 for 5 cycles at value=3 keeps value=3 and cout=0. cin=0 gives the same.

Source files
------------

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N digit counter with up/down, synchronous load, wrap or saturate,
// and a carry/borrow chain so that timer digits can be cascaded without extra latency.
module mod_n_counter #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MODULO    = 10,
   parameter int unsigned RESET_VAL = 0,
   parameter bit          WRAP      = 1'b1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             cin,
   output logic [WIDTH-1:0] value,
   output logic             cout,
   output logic             zero
);

   // The modulus needs WIDTH+1 bits when MODULO == 2**WIDTH.
   localparam logic [WIDTH:0]   ModW   = (WIDTH + 1)'(MODULO);
   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 1);
   localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] One    = WIDTH'(1);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;
   logic             step;
   logic             terminal;

   assign step     = en & cin & ~load;
   assign terminal = up ? (value_q == MaxVal) : (value_q == '0);
   assign cout     = step & terminal & clr;
   assign zero     = (value_q == '0);
   assign value    = value_q;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = ({1'b0, load_val} >= ModW) ? MaxVal : load_val;
      end else if (step) begin
         if (!terminal) begin
            value_d = up ? (value_q + One) : (value_q - One);
         end else if (WRAP) begin
            value_d = up ? '0 : MaxVal;
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         value_q <= RstVal;
      end else begin
         value_q <= value_d;
      end
   end

endmodule
